gaussian_filter: RTL and testbench

Optional 3x3 Gaussian blur stage on the 12-bit RGB444 pixel stream between the camera output buffer and the memory interface. It consumes one pixel per `i_valid` in raster order and emits exactly one pixel per input pixel after a fixed 3-cycle latency. Frame start comes from `i_sof`. When enabled, each colour channel is filtered with kernel [1 2 1; 2 4 2; 1 2 1]/16. When disabled, pixels pass through with the same latency, so downstream timing never changes.

---
 rtl/gaussian_filter.sv | 172 +++++++++++++++++
 tb/tb_gaussian_filter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_filter.sv
// 3x3 Gaussian blur ([1 2 1;2 4 2;1 2 1]/16) on an RGB444 stream with a fixed 3-cycle latency.
// Build option: define GAUSS_ROUND_EN for round-half-up channel results; otherwise results truncate.
module gaussian_filter #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_flush,
    input  logic                  i_enable,
    input  logic                  i_valid,
    input  logic                  i_sof,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic                  o_sof,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_active
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic [XW-1:0]         x_cnt, cur_x;
    logic [YW-1:0]         y_cnt, cur_y;
    logic                  in_fire;

    logic [DATA_WIDTH-1:0] lb0 [IMG_W];
    logic [DATA_WIDTH-1:0] lb1 [IMG_W];
    logic [DATA_WIDTH-1:0] rd0, rd1;

    logic                  s1_valid, s1_sof, s1_filt;
    logic [DATA_WIDTH-1:0] s1_data;

    logic [DATA_WIDTH-1:0] win [3][3];
    logic [DATA_WIDTH-1:0] nxt [3][3];
    logic [7:0]            sum_d  [3];

    logic                  s2_valid, s2_sof, s2_filt;
    logic [DATA_WIDTH-1:0] s2_data;
    logic [7:0]            s2_sum [3];

    logic [3:0]            chan   [3];
    logic [DATA_WIDTH-1:0] filt_pix;

    // A pixel arriving together with a flush is dropped entirely.
    assign in_fire = i_valid & ~i_flush;
    assign cur_x   = i_sof ? '0 : x_cnt;
    assign cur_y   = i_sof ? '0 : y_cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (i_flush) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (i_valid) begin
            if (cur_x == XW'(IMG_W - 1)) begin
                x_cnt <= '0;
                y_cnt <= (cur_y == YW'(IMG_H - 1)) ? '0 : cur_y + YW'(1);
            end else begin
                x_cnt <= cur_x + XW'(1);
                y_cnt <= cur_y;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            o_active <= 1'b0;
        else if (in_fire && i_sof)
            o_active <= i_enable;
    end

    // Line buffers: lb0 holds row y-1, lb1 row y-2; both read before being overwritten.
    always_ff @(posedge i_clk) begin
        if (in_fire) begin
            lb0[cur_x] <= i_data;
            lb1[cur_x] <= lb0[cur_x];
            rd0        <= lb0[cur_x];
            rd1        <= lb1[cur_x];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_filt  <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_sof  <= i_sof;
                s1_data <= i_data;
                s1_filt <= o_active & ~i_sof & (cur_x >= XW'(2)) & (cur_y >= YW'(2));
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            nxt[r][0] = win[r][1];
            nxt[r][1] = win[r][2];
        end
        nxt[0][2] = rd1;
        nxt[1][2] = rd0;
        nxt[2][2] = s1_data;
    end

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            sum_d[c] = 8'(nxt[0][0][4*c +: 4]) + 8'(nxt[0][2][4*c +: 4])
                     + 8'(nxt[2][0][4*c +: 4]) + 8'(nxt[2][2][4*c +: 4])
                     + ((8'(nxt[0][1][4*c +: 4]) + 8'(nxt[1][0][4*c +: 4])
                       + 8'(nxt[1][2][4*c +: 4]) + 8'(nxt[2][1][4*c +: 4])) << 1)
                     + (8'(nxt[1][1][4*c +: 4]) << 2);
        end
    end

    always_ff @(posedge i_clk) begin
        if (s1_valid) begin
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    win[r][k] <= nxt[r][k];
            for (int c = 0; c < 3; c++)
                s2_sum[c] <= sum_d[c];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_filt  <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid & ~i_flush;
            if (s1_valid) begin
                s2_sof  <= s1_sof;
                s2_filt <= s1_filt;
                s2_data <= s1_data;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 3; c++) begin
`ifdef GAUSS_ROUND_EN
            chan[c] = 4'((s2_sum[c] + 8'd8) >> 4);
`else
            chan[c] = s2_sum[c][7:4];
`endif
        end
        filt_pix = {chan[2], chan[1], chan[0]};
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= s2_valid & ~i_flush;
            o_sof   <= s2_valid & s2_sof & ~i_flush;
            if (s2_valid)
                o_data <= s2_filt ? filt_pix : s2_data;
        end
    end

endmodule

// File: tb/tb_gaussian_filter.sv
// Directed, table-driven bench for gaussian_filter on a small 8x6 image.
module tb_gaussian_filter;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;
`ifdef GAUSS_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_sof = 1'b0;
    logic [11:0] i_data = 12'h000;
    logic        o_valid, o_sof, o_active;
    logic [11:0] o_data;

    typedef struct {
        logic        sof_in;
        logic [11:0] data_in;
        logic        sof_exp;
        logic [11:0] data_exp;
    } vec_t;

    typedef struct {
        int         x;
        int         y;
        logic [3:0] rnd;
        logic [3:0] trn;
    } tap_t;

    vec_t        vec [N];
    tap_t        taps [9];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          in_cyc[$];
    int          obs_cyc[$];
    logic [12:0] obs[$];

    gaussian_filter #(.IMG_W(W), .IMG_H(H), .DATA_WIDTH(12)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(i_flush), .i_enable(i_enable),
        .i_valid(i_valid), .i_sof(i_sof), .i_data(i_data),
        .o_valid(o_valid), .o_sof(o_sof), .o_data(o_data), .o_active(o_active)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    always @(negedge i_clk) begin
        if (o_valid === 1'b1) begin
            obs.push_back({o_sof, o_data});
            obs_cyc.push_back(cyc);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic sof, input logic [11:0] data, input logic flush);
        @(posedge i_clk);
        #1;
        i_valid = valid;
        i_sof   = sof;
        i_data  = data;
        i_flush = flush;
        if (valid && !flush) in_cyc.push_back(cyc);
    endtask

    task automatic clearQueues();
        obs.delete();
        obs_cyc.delete();
        in_cyc.delete();
    endtask

    // Impulse frame: F00 at (3,3); the taps list the hand-computed red results per output index.
    function automatic void buildTable(input bit constant, input bit filt, input bit sof_first);
        for (int i = 0; i < N; i++) begin
            vec[i].sof_in   = sof_first && (i == 0);
            vec[i].sof_exp  = sof_first && (i == 0);
            vec[i].data_in  = constant ? 12'h5A3 : ((i == 3 * W + 3) ? 12'hF00 : 12'h000);
            vec[i].data_exp = (constant || !filt) ? vec[i].data_in : 12'h000;
        end
        if (!constant && filt)
            for (int k = 0; k < 9; k++)
                vec[taps[k].y * W + taps[k].x].data_exp = {(ROUND ? taps[k].rnd : taps[k].trn), 8'h00};
    endfunction

    task automatic runFrame(input int max_gap, input int toggle_at);
        for (int i = 0; i < N; i++) begin
            if (i == toggle_at) i_enable = ~i_enable;
            applyStimulus(1'b1, vec[i].sof_in, vec[i].data_in, 1'b0);
            repeat ($urandom_range(max_gap, 0)) applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
        end
        repeat (5) applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
    endtask

    task automatic checkFrame(input string name);
        checkOutput({name, " count"}, obs.size(), N);
        for (int i = 0; i < N && i < obs.size() && i < in_cyc.size(); i++) begin
            checkOutput($sformatf("%s px%0d", name, i), obs[i], {vec[i].sof_exp, vec[i].data_exp});
            checkOutput($sformatf("%s lat%0d", name, i), obs_cyc[i] - in_cyc[i], 3);
        end
        clearQueues();
    endtask

    initial begin
        taps = '{'{3, 3, 4'd1, 4'd0}, '{4, 3, 4'd2, 4'd1}, '{5, 3, 4'd1, 4'd0},
                 '{3, 4, 4'd2, 4'd1}, '{4, 4, 4'd4, 4'd3}, '{5, 4, 4'd2, 4'd1},
                 '{3, 5, 4'd1, 4'd0}, '{4, 5, 4'd2, 4'd1}, '{5, 5, 4'd1, 4'd0}};

        #1 i_rstn = 1'b0;
        #2;
        checkOutput("reset o_valid", o_valid, 0);
        checkOutput("reset o_sof", o_sof, 0);
        checkOutput("reset o_data", o_data, 12'h000);
        checkOutput("reset o_active", o_active, 0);
        @(posedge i_clk);
        #1 i_rstn = 1'b1;

        i_enable = 1'b0;
        applyStimulus(1'b1, 1'b1, 12'hABC, 1'b0);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
        checkOutput("single early valid", o_valid, 0);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
        checkOutput("single valid", o_valid, 1);
        checkOutput("single sof", o_sof, 1);
        checkOutput("single data", o_data, 12'hABC);
        checkOutput("single active", o_active, 0);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
        checkOutput("single one-shot", o_valid, 0);
        clearQueues();

        i_enable = 1'b1;
        buildTable(1'b1, 1'b1, 1'b1);
        runFrame(0, -1);
        checkFrame("const");
        checkOutput("const active", o_active, 1);

        buildTable(1'b0, 1'b1, 1'b1);
        runFrame(0, -1);
        checkFrame("impulse");

        runFrame(5, -1);
        checkFrame("gaps");

        buildTable(1'b0, 1'b1, 1'b0);
        runFrame(0, -1);
        checkFrame("wrap");

        buildTable(1'b0, 1'b1, 1'b1);
        runFrame(0, 10);
        checkFrame("toggle");
        checkOutput("toggle active", o_active, 1);
        buildTable(1'b0, 1'b0, 1'b1);
        runFrame(0, -1);
        checkFrame("bypass");
        checkOutput("bypass active", o_active, 0);

        i_enable = 1'b1;
        buildTable(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, vec[i].sof_in, vec[i].data_in, 1'b0);
        applyStimulus(1'b1, 1'b0, 12'h777, 1'b1);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
        clearQueues();
        repeat (6) applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
        checkOutput("flush drain", obs.size(), 0);
        checkOutput("flush active kept", o_active, 1);
        buildTable(1'b0, 1'b1, 1'b0);
        runFrame(0, -1);
        checkFrame("postflush");

        buildTable(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, vec[i].sof_in, vec[i].data_in, 1'b0);
        #2;
        i_valid = 1'b0;
        i_rstn  = 1'b0;
        #1;
        checkOutput("midreset o_valid", o_valid, 0);
        checkOutput("midreset o_sof", o_sof, 0);
        checkOutput("midreset o_data", o_data, 12'h000);
        checkOutput("midreset o_active", o_active, 0);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
        i_rstn = 1'b1;
        clearQueues();
        repeat (6) applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
        checkOutput("midreset silent", obs.size(), 0);
        runFrame(0, -1);
        checkFrame("postreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
